// File: rtl/uart_blink_cmd.sv
// ---------------------------------------------------------------------------
// UartBlinkCmd (module uart_blink_cmd)
// Remote-control front end for the LED blinker. Receives 8N1 UART bytes on
// rx, decodes the one-byte 'R' command and the two-byte 'P'/'D' commands, and
// holds the resulting LED enable mask and blink half-period for the blinker.
//
// Ports
//   clk              in   1  system clock
//   rst_n            in   1  synchronous, active-low reset
//   rx               in   1  asynchronous UART line, idle high
//   led_mask         out  8  LEDs enabled to blink (1 = blinks)
//   half_period_10ms out  8  blink half-period in 10 ms units, never 0
//   cmd_strobe       out  1  one-cycle pulse when a command is applied
//   cmd_error        out  1  one-cycle pulse on framing error, bad opcode
//                            or argument timeout
// ---------------------------------------------------------------------------
module uart_blink_cmd #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int BAUD         = 115_200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] led_mask,
    output logic [7:0] half_period_10ms,
    output logic       cmd_strobe,
    output logic       cmd_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CNT_W     = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT_CLK  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_HALF_CLK = BIT_CNT_W'(HALF_BIT - 1);
    localparam logic [TO_CNT_W-1:0]  LAST_TO_CLK   = TO_CNT_W'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] OP_PATTERN  = 8'h50;
    localparam logic [7:0] OP_DURATION = 8'h44;
    localparam logic [7:0] OP_RESTORE  = 8'h52;
    localparam logic [7:0] RESET_MASK  = 8'hFF;
    localparam logic [7:0] RESET_HALF  = 8'd50;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
    typedef enum logic {P_WAIT_OP, P_WAIT_ARG} parseState_e;

    logic                 rxMeta_q, rxSync_q;
    rxState_e             rxState_q, rxState_d;
    logic [BIT_CNT_W-1:0] clkCnt_q, clkCnt_d;
    logic [2:0]           bitCnt_q, bitCnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 byteValid_q, byteValid_d;
    logic                 frameErr_q, frameErr_d;

    parseState_e          parseState_q, parseState_d;
    logic                 argIsDur_q, argIsDur_d;
    logic [TO_CNT_W-1:0]  toCnt_q, toCnt_d;
    logic [7:0]           ledMask_q, ledMask_d;
    logic [7:0]           halfPeriod_q, halfPeriod_d;
    logic                 strobe_q, strobe_d;
    logic                 error_q, error_d;

    // Two-flop synchronizer; it resets to the idle-high line level so that
    // leaving reset can never look like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // State registers for the receiver and the command parser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxState_q    <= RX_IDLE;
            clkCnt_q     <= '0;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            byteValid_q  <= 1'b0;
            frameErr_q   <= 1'b0;
            parseState_q <= P_WAIT_OP;
            argIsDur_q   <= 1'b0;
            toCnt_q      <= '0;
            ledMask_q    <= RESET_MASK;
            halfPeriod_q <= RESET_HALF;
            strobe_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rxState_q    <= rxState_d;
            clkCnt_q     <= clkCnt_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            byteValid_q  <= byteValid_d;
            frameErr_q   <= frameErr_d;
            parseState_q <= parseState_d;
            argIsDur_q   <= argIsDur_d;
            toCnt_q      <= toCnt_d;
            ledMask_q    <= ledMask_d;
            halfPeriod_q <= halfPeriod_d;
            strobe_q     <= strobe_d;
            error_q      <= error_d;
        end
    end

    // Receiver: the start bit is re-checked at its midpoint, after which every
    // sample lands mid-bit. The stop bit is sampled mid-bit and the FSM
    // returns to IDLE immediately, leaving half a bit to catch the next start
    // edge of back-to-back traffic.
    always_comb begin
        rxState_d   = rxState_q;
        clkCnt_d    = clkCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                clkCnt_d = '0;
                if (!rxSync_q) begin
                    rxState_d = RX_START;
                    bitCnt_d  = '0;
                end
            end
            RX_START: begin
                if (clkCnt_q == LAST_HALF_CLK) begin
                    clkCnt_d  = '0;
                    rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clkCnt_d = clkCnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clkCnt_q == LAST_BIT_CLK) begin
                    clkCnt_d = '0;
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end
                end else begin
                    clkCnt_d = clkCnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clkCnt_q == LAST_BIT_CLK) begin
                    clkCnt_d    = '0;
                    rxState_d   = RX_IDLE;
                    byteValid_d = rxSync_q;
                    frameErr_d  = !rxSync_q;
                end else begin
                    clkCnt_d = clkCnt_q + 1'b1;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Parser: a received byte always wins over a timeout expiring in the same
    // cycle, and byte/framing events are mutually exclusive, so strobe and
    // error can never pulse together. shift_q still holds the byte while
    // byteValid_q is high because the receiver is then idle.
    always_comb begin
        parseState_d = parseState_q;
        argIsDur_d   = argIsDur_q;
        toCnt_d      = toCnt_q;
        ledMask_d    = ledMask_q;
        halfPeriod_d = halfPeriod_q;
        strobe_d     = 1'b0;
        error_d      = 1'b0;
        case (parseState_q)
            P_WAIT_OP: begin
                toCnt_d = '0;
                if (frameErr_q) begin
                    error_d = 1'b1;
                end else if (byteValid_q) begin
                    case (shift_q)
                        OP_PATTERN: begin
                            parseState_d = P_WAIT_ARG;
                            argIsDur_d   = 1'b0;
                        end
                        OP_DURATION: begin
                            parseState_d = P_WAIT_ARG;
                            argIsDur_d   = 1'b1;
                        end
                        OP_RESTORE: begin
                            ledMask_d    = RESET_MASK;
                            halfPeriod_d = RESET_HALF;
                            strobe_d     = 1'b1;
                        end
                        default: error_d = 1'b1;
                    endcase
                end
            end
            P_WAIT_ARG: begin
                if (frameErr_q) begin
                    error_d      = 1'b1;
                    parseState_d = P_WAIT_OP;
                end else if (byteValid_q) begin
                    if (argIsDur_q) begin
                        halfPeriod_d = (shift_q == 8'h00) ? 8'h01 : shift_q;
                    end else begin
                        ledMask_d = shift_q;
                    end
                    strobe_d     = 1'b1;
                    parseState_d = P_WAIT_OP;
                end else if (toCnt_q == LAST_TO_CLK) begin
                    error_d      = 1'b1;
                    parseState_d = P_WAIT_OP;
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end
            default: parseState_d = P_WAIT_OP;
        endcase
    end

    assign led_mask         = ledMask_q;
    assign half_period_10ms = halfPeriod_q;
    assign cmd_strobe       = strobe_q;
    assign cmd_error        = error_q;

endmodule

// File: tb/tb_uart_blink_cmd.sv
// ---------------------------------------------------------------------------
// TbUartBlinkCmd (module tb_uart_blink_cmd)
// Drives serial bytes into uart_blink_cmd and compares the LED mask, the
// half-period and the running counts of strobe/error pulses against a
// command-level reference model after every byte and every long idle gap.
// ---------------------------------------------------------------------------
module tb_uart_blink_cmd;

    localparam int CLK_FREQ = 2_304_000;
    localparam int BAUD     = 115_200;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int TO_BITS  = 20;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] led_mask;
    logic [7:0] half_period_10ms;
    logic       cmd_strobe;
    logic       cmd_error;

    int nVectors    = 0;
    int nMiscompare = 0;
    int strobeCnt   = 0;
    int errorCnt    = 0;
    int overlapCnt  = 0;

    logic [7:0] expLed;
    logic [7:0] expHalf;
    int         expStrobes;
    int         expErrors;
    logic [7:0] pendOp;

    uart_blink_cmd #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx              (rx),
        .led_mask        (led_mask),
        .half_period_10ms(half_period_10ms),
        .cmd_strobe      (cmd_strobe),
        .cmd_error       (cmd_error)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (cmd_strobe === 1'b1) strobeCnt++;
        if (cmd_error === 1'b1) errorCnt++;
        if (cmd_strobe === 1'b1 && cmd_error === 1'b1) overlapCnt++;
    end

    // Reference model: what a complete byte means at command level.
    task automatic modelByte(input logic [7:0] b, input bit goodStop);
        if (!goodStop) begin
            expErrors++;
            pendOp = 8'h00;
        end else if (pendOp == 8'h50) begin
            expLed = b;
            expStrobes++;
            pendOp = 8'h00;
        end else if (pendOp == 8'h44) begin
            expHalf = (b == 8'h00) ? 8'h01 : b;
            expStrobes++;
            pendOp = 8'h00;
        end else if (b == 8'h50 || b == 8'h44) begin
            pendOp = b;
        end else if (b == 8'h52) begin
            expLed  = 8'hFF;
            expHalf = 8'd50;
            expStrobes++;
        end else begin
            expErrors++;
        end
    endtask

    task automatic modelReset();
        expLed  = 8'hFF;
        expHalf = 8'd50;
        pendOp  = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompare++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".led_mask"}, 32'(led_mask), 32'(expLed));
        checkOutput({tag, ".half_period"}, 32'(half_period_10ms), 32'(expHalf));
        checkOutput({tag, ".strobes"}, 32'(strobeCnt), 32'(expStrobes));
        checkOutput({tag, ".errors"}, 32'(errorCnt), 32'(expErrors));
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Sends one frame, checks right after its stop bit, then idles for
    // gapBits. A gap of at least 25 bits outlasts the argument window.
    task automatic applyStimulus(input string tag, input logic [7:0] b,
                                 input bit goodStop, input int gapBits);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = goodStop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        modelByte(b, goodStop);
        checkAll(tag);
        if (gapBits > 0) begin
            idleBits(gapBits);
        end
        if (gapBits >= 25) begin
            if (pendOp != 8'h00) begin
                expErrors++;
                pendOp = 8'h00;
            end
            checkAll({tag, ".gap"});
        end
    endtask

    initial begin
        logic [7:0] b;
        bit         good;
        int         gap;
        int         r;
        rx         = 1'b1;
        rst_n      = 1'b0;
        expStrobes = 0;
        expErrors  = 0;
        modelReset();

        // Reset values.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAll("reset");
        idleBits(2);

        // Pattern command.
        applyStimulus("p0f_op", 8'h50, 1'b1, 0);
        applyStimulus("p0f_arg", 8'h0F, 1'b1, 2);

        // Duration zero clamps to one, then a normal value.
        applyStimulus("d00_op", 8'h44, 1'b1, 2);
        applyStimulus("d00_arg", 8'h00, 1'b1, 2);
        applyStimulus("d19_op", 8'h44, 1'b1, 0);
        applyStimulus("d19_arg", 8'h19, 1'b1, 2);

        // Argument timeout, then an orphan argument is a bad opcode.
        applyStimulus("timeout_op", 8'h50, 1'b1, 25);
        applyStimulus("orphan", 8'h0F, 1'b1, 2);

        // Framing error, then a short glitch on the idle line.
        applyStimulus("badstop", 8'h50, 1'b0, 2);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idleBits(3);
        checkAll("glitch");

        // Restore, and argument bytes that look like opcodes.
        applyStimulus("p00_op", 8'h50, 1'b1, 0);
        applyStimulus("p00_arg", 8'h00, 1'b1, 2);
        applyStimulus("restore", 8'h52, 1'b1, 2);
        applyStimulus("pR_op", 8'h50, 1'b1, 0);
        applyStimulus("pR_arg", 8'h52, 1'b1, 2);

        // Reset in the middle of an argument byte.
        applyStimulus("midrst_op", 8'h50, 1'b1, 0);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        idleBits(12);
        checkAll("midrst");
        applyStimulus("paa_op", 8'h50, 1'b1, 0);
        applyStimulus("paa_arg", 8'hAA, 1'b1, 2);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 6);
            case (r)
                0: b = 8'h50;
                1: b = 8'h44;
                2: b = 8'h52;
                3: b = 8'h00;
                default: b = 8'($urandom());
            endcase
            good = ($urandom_range(0, 7) != 0);
            r    = $urandom_range(0, 5);
            gap  = (r == 0) ? 25 : ((r < 3) ? 0 : 2);
            if (!good && gap == 0) gap = 2;
            applyStimulus($sformatf("rnd%0d", n), b, good, gap);
        end

        idleBits(2);
        checkOutput("no_overlap", 32'(overlapCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompare);
        $finish;
    end

endmodule
